// File: rtl/wb_core_master_if.sv
// Wishbone pipelined bus bundle shared by the core-side master and its slaves.
// Clock and reset travel with the bus so every agent sees the same domain.
interface wishbone_if (
  input logic clk_i,
  input logic rst_ni
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_m;
  logic [31:0] data_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    input  clk_i, rst_ni, data_s, ack, err, stall,
    output cyc, stb, we, sel, addr, data_m
  );

  modport slave (
    input  clk_i, rst_ni, cyc, stb, we, sel, addr, data_m,
    output data_s, ack, err, stall
  );
endinterface

// File: rtl/wb_core_master.sv
// Converts an Ibex-style req/gnt/rvalid port into pipelined Wishbone cycles,
// tracking outstanding transactions and aborting the cycle on a response timeout.
module wb_core_master #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 255
) (
  wishbone_if.master  wb,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int CW = 4;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          w_abort, w_stb, w_gnt, w_resp, w_timeout;

  assign w_abort = (r_state == ABORT);
  // Reset gates the strobe combinationally so a held req_i cannot leak onto the bus.
  assign w_stb   = wb.rst_ni & req_i & (r_cnt < CW'(MAX_OUTSTANDING)) & ~w_abort;
  assign w_gnt   = w_stb & ~wb.stall;
  // A response with nothing outstanding is spurious and is dropped here.
  assign w_resp  = (wb.ack | wb.err) & (r_cnt != '0) & ~w_abort;
  assign w_timeout = (TIMEOUT != 0) && (r_state == BUSY) &&
                     (r_timer == TW'(TIMEOUT)) && !w_resp && !w_gnt;

  always_ff @(posedge wb.clk_i or negedge wb.rst_ni) begin
    if (!wb.rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    case (r_state)
      ABORT: begin
        // One error response per cycle until every outstanding slot is retired.
        w_timer_nxt = '0;
        w_cnt_nxt   = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, w_gnt} - {{(CW-1){1'b0}}, w_resp};
        if (w_resp || w_gnt || r_state == IDLE) w_timer_nxt = '0;
        else                                     w_timer_nxt = r_timer + TW'(1);
        if (w_timeout)               w_state_nxt = ABORT;
        else if (w_cnt_nxt != '0)    w_state_nxt = BUSY;
        else                         w_state_nxt = IDLE;
      end
    endcase
  end

  assign wb.cyc    = w_stb | (wb.rst_ni & (r_state == BUSY));
  assign wb.stb    = w_stb;
  assign wb.we     = we_i;
  assign wb.sel    = be_i;
  assign wb.addr   = addr_i;
  assign wb.data_m = wdata_i;

  assign gnt_o    = w_gnt;
  assign rvalid_o = wb.rst_ni & (w_abort | w_resp);
  assign err_o    = wb.rst_ni & (w_abort | (w_resp & wb.err));
  assign rdata_o  = w_abort ? '0 : wb.data_s;

endmodule

// File: tb/tb_wb_core_master.sv
// Bench for wb_core_master: directed scenarios followed by randomized traffic,
// with an in-order slave and a transaction scoreboard kept in queues.
module tb_wb_core_master;
  localparam int MAXO = 2;
  localparam int TO   = 6;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    int          due;
  } txn_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err_o;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  wishbone_if wb (.clk_i(clk), .rst_ni(rst_n));

  wb_core_master #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)) dut (
    .wb(wb), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err_o)
  );

  txn_t sq[$];
  txn_t eq[$];
  int   n_tests = 0, n_fail = 0, now = 0;
  bit   rules_on = 1, silent = 0, force_ack = 0;
  int   dly = 1;
  bit   s_gnt, s_stb, s_cyc, s_rv, s_err;
  logic [31:0] s_rdata;
  int   rv_cnt = 0, err_cnt = 0, max_out = 0;

  function automatic logic [31:0] rdf(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  function automatic bit is_err_addr(logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit   drv;
    int   outst;
    bit   e_stb;
    txn_t t;
    drv = 0;
    if (force_ack) begin
      wb.ack = 1'b1; wb.err = 1'b0; wb.data_s = 32'h1234_5678;
    end else if (!silent && sq.size() > 0 && sq[0].due <= now) begin
      drv = 1;
      wb.ack    = !is_err_addr(sq[0].addr);
      wb.err    = is_err_addr(sq[0].addr);
      wb.data_s = rdf(sq[0].addr);
    end else begin
      wb.ack = 1'b0; wb.err = 1'b0; wb.data_s = $urandom;
    end
    #3;
    s_gnt = gnt; s_stb = wb.stb; s_cyc = wb.cyc;
    s_rv = rvalid; s_err = err_o; s_rdata = rdata;
    outst = eq.size();
    if (rules_on) begin
      e_stb = req && (outst < MAXO);
      chk("stb", s_stb, e_stb);
      chk("gnt", s_gnt, e_stb && !wb.stall);
      chk("cyc", s_cyc, e_stb || (outst > 0));
      chk("rvalid", s_rv, (wb.ack || wb.err) && (outst > 0));
      if (s_stb) begin
        chk("addr_pass", wb.addr, addr);
        chk("sel_pass", {28'b0, wb.sel}, {28'b0, be});
        chk("we_pass", wb.we, we);
        chk("wdata_pass", wb.data_m, wdata);
      end
      if (s_rv && eq.size() > 0) begin
        t = eq.pop_front();
        chk("rsp_err", s_err, is_err_addr(t.addr));
        if (!is_err_addr(t.addr)) chk("rsp_data", s_rdata, rdf(t.addr));
      end
    end
    if (s_rv) begin
      rv_cnt++;
      if (s_err) err_cnt++;
    end
    if (drv) void'(sq.pop_front());
    if (s_gnt) begin
      t.addr = addr; t.we = we; t.due = now + dly;
      sq.push_back(t);
      eq.push_back(t);
    end
    if (eq.size() > max_out) max_out = eq.size();
    @(posedge clk);
    #1;
    now++;
  endtask

  initial begin
    int ngr, nstall, cyc_gap, first_rv, g3;
    req = 0; we = 0; be = 4'hF; addr = 0; wdata = 0;
    wb.ack = 0; wb.err = 0; wb.stall = 0; wb.data_s = 0;
    #1;
    rst_n = 0;
    req = 1; addr = 32'h100; wb.ack = 1;
    #2;
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err_o, 0);
    wb.ack = 0; req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Single read with a zero-wait slave
    dly = 1; req = 1; we = 0; be = 4'hF; addr = 32'h100; wdata = 0;
    cycle();
    chk("t1_gnt", s_gnt, 1);
    req = 0;
    cycle();
    chk("t1_rvalid", s_rv, 1);
    chk("t1_rdata", s_rdata, 32'hDEADBEEF);
    chk("t1_err", s_err, 0);
    cycle();
    chk("t1_cyc_low", s_cyc, 0);

    // Four writes, second one stalled for two cycles
    ngr = 0; nstall = 0; cyc_gap = 0; rv_cnt = 0; max_out = 0;
    for (int i = 0; i < 30 && (ngr < 4 || eq.size() > 0); i++) begin
      req = (ngr < 4); we = 1; be = 4'hF;
      addr = 32'h200 + 32'(ngr * 4); wdata = rdf(addr);
      wb.stall = (ngr == 1 && nstall < 2);
      if (wb.stall) nstall++;
      cycle();
      if (s_gnt) ngr++;
      if (!s_cyc) cyc_gap++;
    end
    wb.stall = 0; req = 0;
    chk("t2_grants", ngr, 4);
    chk("t2_rvalids", rv_cnt, 4);
    chk("t2_cyc_gaps", cyc_gap, 0);
    chk("t2_max_out_le2", (max_out <= 2), 1);

    // Slow slave: acks five cycles after the grant, req held high
    dly = 5; ngr = 0; first_rv = -1; g3 = -1;
    for (int i = 0; i < 30 && (ngr < 3 || eq.size() > 0); i++) begin
      req = (ngr < 3); we = 0; be = 4'h3; addr = 32'h300 + 32'(ngr * 4); wdata = 0;
      cycle();
      if (s_rv && first_rv < 0) first_rv = i;
      if (s_gnt) begin
        if (ngr == 2) g3 = i;
        ngr++;
      end
    end
    req = 0; dly = 1;
    chk("t3_first_ack_cycle", first_rv, 5);
    chk("t3_third_gnt_cycle", g3, 6);

    // Error on the second of three reads
    ngr = 0; rv_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 20 && (ngr < 3 || eq.size() > 0); i++) begin
      req = (ngr < 3); we = 0; be = 4'hF;
      addr = (ngr == 1) ? 32'hE000_0404 : 32'h400 + 32'(ngr * 4);
      cycle();
      if (s_gnt) ngr++;
    end
    req = 0;
    chk("t4_rvalids", rv_cnt, 3);
    chk("t4_errors", err_cnt, 1);
    cycle();
    chk("t4_cyc_idle", s_cyc, 0);

    // Timeout: two grants, silent slave
    rules_on = 0; silent = 1;
    req = 1; we = 0; addr = 32'h500;
    cycle();
    chk("to_gnt0", s_gnt, 1);
    addr = 32'h504;
    cycle();
    chk("to_gnt1", s_gnt, 1);
    req = 0;
    for (int i = 0; i <= TO; i++) begin
      cycle();
      chk("to_wait_cyc", s_cyc, 1);
      chk("to_wait_rv", s_rv, 0);
    end
    req = 1; addr = 32'h508;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("to_ab_cyc", s_cyc, 0);
      chk("to_ab_stb", s_stb, 0);
      chk("to_ab_gnt", s_gnt, 0);
      chk("to_ab_rv", s_rv, 1);
      chk("to_ab_err", s_err, 1);
      chk("to_ab_rdata", s_rdata, 0);
    end
    req = 0;
    cycle();
    chk("to_idle_cyc", s_cyc, 0);
    chk("to_idle_rv", s_rv, 0);
    force_ack = 1;
    cycle();
    chk("to_late_ack_rv", s_rv, 0);
    force_ack = 0;
    sq.delete(); eq.delete();
    silent = 0; rules_on = 1;

    // Reset with two transactions outstanding
    silent = 1;
    req = 1; addr = 32'h600;
    cycle();
    addr = 32'h604;
    cycle();
    chk("rs_outstanding", eq.size(), 2);
    wb.ack = 1;
    rst_n = 0;
    #1;
    chk("rs_cyc", wb.cyc, 0);
    chk("rs_stb", wb.stb, 0);
    chk("rs_gnt", gnt, 0);
    chk("rs_rvalid", rvalid, 0);
    wb.ack = 0; req = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    sq.delete(); eq.delete(); silent = 0;
    req = 1; we = 0; addr = 32'h100; dly = 1;
    cycle();
    chk("rs_new_gnt", s_gnt, 1);
    req = 0;
    cycle();
    chk("rs_new_rvalid", s_rv, 1);
    chk("rs_new_rdata", s_rdata, 32'hDEADBEEF);

    // Randomized traffic with random stalls and ack latency
    req = 0;
    for (int i = 0; i < 400; i++) begin
      if (!req || s_gnt) begin
        req   = ($urandom_range(0, 3) != 0);
        we    = $urandom_range(0, 1);
        be    = 4'($urandom);
        addr  = $urandom;
        addr[31:28] = ($urandom_range(0, 7) == 0) ? 4'hE : 4'h1;
        wdata = $urandom;
      end
      wb.stall = ($urandom_range(0, 3) == 0);
      dly = $urandom_range(1, 3);
      cycle();
    end
    req = 0; wb.stall = 0;
    for (int i = 0; i < 20 && eq.size() > 0; i++) cycle();
    chk("rand_drained", eq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_core_master.md
# wb_core_master

Wishbone pipelined bus master that converts an Ibex-style core request interface (req/gnt/rvalid) into `wishbone_if.master` cycles. It sits between the core's instruction or data port and the Wishbone interconnect, in front of slaves such as the single-port instruction/data RAMs and peripherals. It tracks up to `MAX_OUTSTANDING` pipelined transactions and holds `cyc` across bursts. A response timeout aborts the cycle and returns error responses for every transaction still outstanding.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum issued-but-unacknowledged transactions, range 1..15.
- `TIMEOUT`, default 255: cycles without ack/err (while outstanding > 0) before abort; 0 disables the timeout.
- `wb.clk_i`  in  1  clock, taken from the interface.
- `wb.rst_ni`  in  1  reset, asynchronous, active-low, taken from the interface.
- `wb`  modport master  -  `cyc`, `stb`, `we`, `sel[3:0]`, `addr[31:0]`, `data_m[31:0]` out; `data_s[31:0]`, `ack`, `err`, `stall` in.
- `req_i`  in  1  core request.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables.
- `addr_i`  in  32  byte address; passed through unmodified.
- `wdata_i`  in  32  write data.
- `gnt_o`  out  1  request accepted this cycle.
- `rvalid_o`  out  1  response valid, one pulse per granted request.
- `rdata_o`  out  32  read data, valid with `rvalid_o`.
- `err_o`  out  1  error response, valid with `rvalid_o`.

## Operation
- State machine states: IDLE, BUSY, ABORT.
  - IDLE: outstanding count `cnt` = 0.
  - BUSY: `cnt` > 0.
  - ABORT: draining after a timeout.
- Issue:
  - `stb = req_i & (cnt < MAX_OUTSTANDING) & state != ABORT`.
  - `gnt_o = stb & ~stall`.
  - `we`, `sel`, `addr` and `data_m` mirror `we_i`, `be_i`, `addr_i`, `wdata_i` combinationally.
  - `sel` is driven for reads too.
- Cycle: `cyc = stb | (state == BUSY)`. `cyc` deasserts the cycle after the last ack when no new request is issued.
- Counter update each cycle: `cnt += gnt_o`, `cnt -= (ack | err)`.
  - Simultaneous grant and response leaves `cnt` unchanged.
  - ack/err with `cnt` = 0 is spurious: ignored, no `rvalid_o`, counter does not underflow.
- Response:
  - `rvalid_o = (ack | err) & cnt > 0 & state != ABORT`.
  - `rdata_o = data_s`.
  - `err_o = err`.
  - Responses are returned in issue order. Wishbone slaves are in-order, so no reordering is needed.
- Timeout:
  - `timer` clears on IDLE, on any ack/err, and on any grant.
  - Otherwise `timer` increments while in BUSY.
  - When `timer == TIMEOUT` (and `TIMEOUT` != 0), go to ABORT.
- ABORT:
  - `cyc` = 0 and `stb` = 0.
  - Bus ack/err are ignored.
  - Drive `rvalid_o` = 1 and `err_o` = 1 for one cycle per outstanding transaction, decrementing `cnt`.
  - `rdata_o` = 0 during ABORT.
  - Enter IDLE when `cnt` reaches 0.
  - `gnt_o` = 0 for the whole of ABORT.
- Reset asserted mid-operation: state returns to IDLE immediately and in-flight transactions are discarded with no responses.

## Timing
- Reset values: state IDLE, `cnt` 0, `timer` 0.
- During reset `cyc`, `stb` and `gnt_o` are forced 0 regardless of `req_i`. `rvalid_o` and `err_o` are forced 0 during reset.
- Grant is combinational in the request cycle when `stall` = 0.
- A zero-wait slave (ack registered one cycle after `stb`) gives `rvalid_o` one cycle after `gnt_o`.
- Back-to-back requests sustain one grant per clock when `MAX_OUTSTANDING` ≥ 2 and the slave acks in 1 cycle.
- With `MAX_OUTSTANDING` = 1, throughput is one transaction per 2 cycles.
- `stall` = 1 holds `stb` and the request fields stable (core holds `req_i`) and issues no grant; `timer` does not count while `cnt` = 0.
- Timeout to ABORT entry: TIMEOUT+1 cycles after the last grant/response. The first error `rvalid_o` occurs in the first ABORT cycle.

## Test plan
- Single read, addr 0x100, slave acks next cycle with data_s 0xDEADBEEF -> `gnt_o` in cycle 0; `rvalid_o`=1, `rdata_o`=0xDEADBEEF, `err_o`=0 in cycle 1; `cyc` low in cycle 2.
- Four back-to-back writes, be 0xF, with `stall` high for 2 cycles on the second -> exactly 4 grants, 4 rvalids in order, `cyc` continuous, `cnt` never exceeds 2.
- `MAX_OUTSTANDING`=2, slave delays acks 5 cycles, `req_i` held high -> third request gets no `stb` until the first ack; `gnt_o` follows in the same cycle the count drops.
- Slave returns `err` on the second of three reads -> `rvalid_o` three times; `err_o` only on the second; `cnt` returns to 0.
- `TIMEOUT`=4, two requests granted, slave silent -> after 5 idle cycles `cyc`=0; two consecutive cycles with `rvalid_o`=1, `err_o`=1; back to IDLE; a late ack produces no `rvalid_o`.
- Assert `rst_ni` low with 2 outstanding -> `cyc`, `stb`, `gnt_o`, `rvalid_o` go 0 asynchronously; after release a new read completes normally.
